// File: rtl/arm_pkg.sv
// Shared ARM core definitions: flag-class encoding and NZCV bit positions.
// The condition-check logic imports the same constants.
package arm_pkg;

    typedef enum logic [1:0] {
        FLAG_LOGIC = 2'b00,
        FLAG_ADD   = 2'b01,
        FLAG_SUB   = 2'b10,
        FLAG_NONE  = 2'b11
    } flag_kind_e;

    localparam int unsigned STATUS_C = 3;
    localparam int unsigned STATUS_V = 2;
    localparam int unsigned STATUS_N = 1;
    localparam int unsigned STATUS_Z = 0;

endpackage

// File: rtl/flag_gen.sv
// Combinational NZCV candidate generation from the execute-stage ALU result.
// LOGIC and NONE pass the current C and V through unchanged.
module flag_gen
    import arm_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [1:0]       op_kind,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [WIDTH-1:0] result,
    input  logic             carry_out,
    input  logic             c_cur,
    input  logic             v_cur,
    output logic [3:0]       flags
);

    logic a_msb;
    logic b_msb;
    logic r_msb;
    logic v_add;
    logic v_sub;
    logic unused_low_bits;

    assign a_msb = operand_a[WIDTH-1];
    assign b_msb = operand_b[WIDTH-1];
    assign r_msb = result[WIDTH-1];

    assign v_add = (a_msb == b_msb) && (r_msb != a_msb);
    assign v_sub = (a_msb != b_msb) && (r_msb != a_msb);

    // Only the operand sign bits feed the overflow terms.
    assign unused_low_bits = ^{operand_a[WIDTH-2:0], operand_b[WIDTH-2:0]};

    always_comb begin
        flags           = '0;
        flags[STATUS_N] = r_msb;
        flags[STATUS_Z] = (result == '0);
        flags[STATUS_C] = c_cur;
        flags[STATUS_V] = v_cur;
        case (flag_kind_e'(op_kind))
            FLAG_ADD: begin
                flags[STATUS_C] = carry_out;
                flags[STATUS_V] = v_add;
            end
            FLAG_SUB: begin
                flags[STATUS_C] = carry_out;
                flags[STATUS_V] = v_sub;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/status_flag_unit.sv
// Architectural NZCV status register with flush/freeze and a one-deep
// save/restore slot for exception entry and return.
module status_flag_unit
    import arm_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    input  logic             set_flags,
    input  logic [1:0]       op_kind,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [WIDTH-1:0] result,
    input  logic             carry_out,
    input  logic             flush,
    input  logic             freeze,
    input  logic             sr_save,
    input  logic             sr_restore,
    output logic [3:0]       status,
    output logic [3:0]       status_next,
    output logic [3:0]       saved_status
);

    logic [3:0] cand_flags;
    logic [3:0] saved_next;
    logic       update;
    logic       restore;
    logic       save;

    flag_gen #(
        .WIDTH(WIDTH)
    ) u_flag_gen (
        .op_kind   (op_kind),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .result    (result),
        .carry_out (carry_out),
        .c_cur     (status[STATUS_C]),
        .v_cur     (status[STATUS_V]),
        .flags     (cand_flags)
    );

    assign update  = op_valid & set_flags & (op_kind != FLAG_NONE) & ~flush & ~freeze;
    assign restore = sr_restore & ~freeze;
    assign save    = sr_save & ~freeze;

    // Slot always captures the pre-update status, so save+restore swaps.
    always_comb begin
        status_next = status;
        saved_next  = saved_status;
        if (restore) begin
            status_next = saved_status;
        end else if (update) begin
            status_next = cand_flags;
        end
        if (save) begin
            saved_next = status;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status       <= '0;
            saved_status <= '0;
        end else begin
            status       <= status_next;
            saved_status <= saved_next;
        end
    end

endmodule

// File: tb/tb_status_flag_unit.sv
// Self-checking bench for status_flag_unit: directed scenarios with literal
// expectations plus randomized traffic against an arithmetic reference model.
module tb_status_flag_unit;

    logic        clk;
    logic        rst_n;
    logic        op_valid;
    logic        set_flags;
    logic [1:0]  op_kind;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [31:0] result;
    logic        carry_out;
    logic        flush;
    logic        freeze;
    logic        sr_save;
    logic        sr_restore;
    logic [3:0]  status;
    logic [3:0]  status_next;
    logic [3:0]  saved_status;

    int unsigned n_cmp;
    int unsigned n_bad;
    logic [3:0]  m_status;
    logic [3:0]  m_saved;

    status_flag_unit #(
        .WIDTH(32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .op_valid     (op_valid),
        .set_flags    (set_flags),
        .op_kind      (op_kind),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .result       (result),
        .carry_out    (carry_out),
        .flush        (flush),
        .freeze       (freeze),
        .sr_save      (sr_save),
        .sr_restore   (sr_restore),
        .status       (status),
        .status_next  (status_next),
        .saved_status (saved_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference flags from signed/unsigned arithmetic, packed {C,V,N,Z}.
    function automatic logic [3:0] ref_flags(input logic [1:0] k, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] r,
                                             input logic co, input logic [3:0] cur);
        longint s;
        logic   c;
        logic   v;
        c = cur[3];
        v = cur[2];
        if (k == 2'd1) begin
            s = longint'($signed(a)) + longint'($signed(b));
            c = co;
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end else if (k == 2'd2) begin
            s = longint'($signed(a)) - longint'($signed(b));
            c = co;
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end
        return {c, v, r[31], (r == 32'd0)};
    endfunction

    task automatic drive(input logic v, input logic sf, input logic [1:0] k,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
                         input logic co, input logic fl, input logic fz,
                         input logic sv, input logic rs);
        op_valid = v; set_flags = sf; op_kind = k;
        operand_a = a; operand_b = b; result = r; carry_out = co;
        flush = fl; freeze = fz; sr_save = sv; sr_restore = rs;
    endtask

    // Called at a falling edge: drive, check bypass, commit model at the
    // rising edge, then check registered outputs at the next falling edge.
    task automatic run_cycle(input logic v, input logic sf, input logic [1:0] k,
                             input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
                             input logic co, input logic fl, input logic fz,
                             input logic sv, input logic rs);
        logic [3:0] exp_next;
        logic [3:0] exp_saved;
        drive(v, sf, k, a, b, r, co, fl, fz, sv, rs);
        exp_next  = m_status;
        exp_saved = m_saved;
        if (!fz) begin
            if (rs) exp_next = m_saved;
            else if (v && sf && k != 2'd3 && !fl) exp_next = ref_flags(k, a, b, r, co, m_status);
            if (sv) exp_saved = m_status;
        end
        #1;
        chk("status_next", status_next, exp_next);
        @(posedge clk);
        m_status = exp_next;
        m_saved  = exp_saved;
        @(negedge clk);
        chk("status", status, m_status);
        chk("saved_status", saved_status, m_saved);
    endtask

    task automatic add_op(input logic [31:0] a, input logic [31:0] b, input logic sv, input logic rs);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        run_cycle(1, 1, 2'd1, a, b, s[31:0], s[32], 0, 0, sv, rs);
    endtask

    task automatic sub_op(input logic [31:0] a, input logic [31:0] b, input logic sf, input logic fl);
        run_cycle(1, sf, 2'd2, a, b, a - b, (a >= b), fl, 0, 0, 0);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        n_cmp = 0;
        n_bad = 0;
        m_status = '0;
        m_saved = '0;
        rst_n = 1'b0;
        drive(0, 0, 2'd3, '0, '0, '0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("reset_status", status, 4'b0000);
        chk("reset_saved", saved_status, 4'b0000);
        rst_n = 1'b1;

        // Signed overflow on ADD: N and V set, no carry.
        add_op(32'h7FFF_FFFF, 32'h0000_0001, 0, 0);
        chk("add_ovf_lit", status, 4'b0110);

        // Equal SUB: Z and C (no borrow); S=0 and flush leave it alone.
        sub_op(32'd5, 32'd5, 1, 0);
        chk("sub_eq_lit", status, 4'b1001);
        add_op(32'h7FFF_FFFF, 32'h0000_0001, 0, 0);
        sub_op(32'd5, 32'd5, 0, 0);
        chk("sub_nosf_lit", status, 4'b0110);
        sub_op(32'd5, 32'd5, 1, 1);
        chk("sub_flush_lit", status, 4'b0110);

        // LOGIC keeps C and V; NONE changes nothing.
        add_op(32'h8000_0000, 32'h8000_0001, 0, 0);
        chk("add_cv_lit", status, 4'b1100);
        run_cycle(1, 1, 2'd0, 32'hF0F0_0000, 32'h0F0F_0000, 32'd0, 0, 0, 0, 0, 0);
        chk("logic_lit", status, 4'b1101);
        add_op(32'h8000_0000, 32'h8000_0001, 0, 0);
        run_cycle(1, 1, 2'd3, 32'hF0F0_0000, 32'h0F0F_0000, 32'd0, 0, 0, 0, 0, 0);
        chk("none_lit", status, 4'b1100);

        // Save with concurrent update, then restore beats update.
        sub_op(32'd5, 32'd5, 1, 0);
        add_op(32'h7FFF_FFFF, 32'h0000_0001, 1, 0);
        chk("save_upd_status", status, 4'b0110);
        chk("save_upd_slot", saved_status, 4'b1001);
        add_op(32'h8000_0000, 32'h8000_0001, 0, 1);
        chk("restore_wins", status, 4'b1001);

        // Save and restore together swap the two registers.
        add_op(32'h7FFF_FFFF, 32'h0000_0001, 0, 0);
        run_cycle(0, 0, 2'd3, '0, '0, '0, 0, 0, 0, 1, 1);
        chk("swap_status", status, 4'b1001);
        chk("swap_slot", saved_status, 4'b0110);

        // Freeze overrides everything for three cycles.
        for (int i = 0; i < 3; i++) begin
            run_cycle(1, i[0], 2'd1, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 0, 0, 1, ~i[0], i[0]);
            chk("freeze_status", status, 4'b1001);
            chk("freeze_slot", saved_status, 4'b0110);
        end

        // Randomized traffic with self-consistent ALU results.
        for (int i = 0; i < 400; i++) begin
            logic [1:0]  k;
            logic [31:0] a;
            logic [31:0] b;
            logic [31:0] r;
            logic [32:0] s;
            logic        co;
            k = 2'($urandom_range(0, 3));
            a = pick_operand();
            b = pick_operand();
            co = 1'($urandom);
            case (k)
                2'd1: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; co = s[32]; end
                2'd2: begin r = a - b; co = (a >= b); end
                default: r = ($urandom_range(0, 3) == 0) ? 32'd0 : (a ^ b);
            endcase
            run_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, k, a, b, r, co,
                      $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                      $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
        end

        // Asynchronous reset between edges discards a pending update.
        add_op(32'h8000_0000, 32'h8000_0000, 0, 0);
        chk("pre_rst_status", status, 4'b1101);
        add_op(32'h8000_0000, 32'h8000_0000, 1, 0);
        chk("pre_rst_slot", saved_status, 4'b1101);
        drive(1, 1, 2'd1, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 0, 0, 0, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_status", status, 4'b0000);
        chk("async_rst_slot", saved_status, 4'b0000);
        @(posedge clk);
        @(negedge clk);
        chk("held_rst_status", status, 4'b0000);
        chk("held_rst_slot", saved_status, 4'b0000);
        rst_n = 1'b1;
        m_status = '0;
        m_saved = '0;
        add_op(32'h7FFF_FFFF, 32'h0000_0001, 0, 0);
        chk("post_rst_update", status, 4'b0110);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
